// File: rtl/sync_edge_event_multi.sv
// Multi-channel async input receiver: N-flop synchroniser, stability filter,
// mode-selectable edge pulses and sticky event flags with overflow and masked irq.
module sync_edge_event_multi #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_W      = 4,
    parameter logic        RST_VAL     = 1'b0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [NUM_CH-1:0]     async_in,
    input  logic [2*NUM_CH-1:0]   edge_mode,
    input  logic [FILT_W-1:0]     filt_thr,
    input  logic [NUM_CH-1:0]     evt_clr,
    input  logic [NUM_CH-1:0]     irq_en,
    output logic [NUM_CH-1:0]     lvl_out,
    output logic [NUM_CH-1:0]     pulse_out,
    output logic [NUM_CH-1:0]     evt_flag,
    output logic [NUM_CH-1:0]     evt_ovf,
    output logic                  irq
);

    logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
    logic [NUM_CH-1:0] sync_d [SYNC_STAGES];
    logic [FILT_W-1:0] cnt_q  [NUM_CH];
    logic [FILT_W-1:0] cnt_d  [NUM_CH];
    logic [NUM_CH-1:0] sync_last;
    logic [NUM_CH-1:0] lvl_q, lvl_d;
    logic [NUM_CH-1:0] pulse_q, pulse_d;
    logic [NUM_CH-1:0] flag_q, flag_d;
    logic [NUM_CH-1:0] ovf_q, ovf_d;
    logic              irq_q, irq_d;

    always_comb begin
        sync_d[0] = async_in;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

    assign sync_last = sync_q[SYNC_STAGES-1];

    // Accept a new level only once it has differed for filt_thr+1 consecutive cycles;
    // the pulse is registered alongside the level so both change on the same edge.
    always_comb begin
        lvl_d   = lvl_q;
        pulse_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = '0;
            if (sync_last[i] != lvl_q[i]) begin
                if (cnt_q[i] >= filt_thr) begin
                    lvl_d[i]   = sync_last[i];
                    pulse_d[i] = sync_last[i] ? edge_mode[2*i] : edge_mode[2*i+1];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // A pulse coinciding with a clear keeps the flag set but drops the overflow.
    always_comb begin
        flag_d = pulse_q | (flag_q & ~evt_clr);
        ovf_d  = ~evt_clr & (ovf_q | (pulse_q & flag_q));
        irq_d  = |(flag_q & irq_en);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= {NUM_CH{RST_VAL}};
            end
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
            lvl_q   <= {NUM_CH{RST_VAL}};
            pulse_q <= '0;
            flag_q  <= '0;
            ovf_q   <= '0;
            irq_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            lvl_q   <= lvl_d;
            pulse_q <= pulse_d;
            flag_q  <= flag_d;
            ovf_q   <= ovf_d;
            irq_q   <= irq_d;
        end
    end

    assign lvl_out   = lvl_q;
    assign pulse_out = pulse_q;
    assign evt_flag  = flag_q;
    assign evt_ovf   = ovf_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_sync_edge_event_multi.sv
// Directed bench for sync_edge_event_multi: latency, filtering, edge modes,
// event flag/overflow/clear behaviour, irq masking and mid-operation reset.
module tb_sync_edge_event_multi;

    logic       clk;
    logic       rstn;
    logic [3:0] async_in;
    logic [7:0] edge_mode;
    logic [3:0] filt_thr;
    logic [3:0] evt_clr;
    logic [3:0] irq_en;
    logic [3:0] lvl_out;
    logic [3:0] pulse_out;
    logic [3:0] evt_flag;
    logic [3:0] evt_ovf;
    logic       irq;

    int checks   = 0;
    int failures = 0;

    sync_edge_event_multi #(
        .NUM_CH      (4),
        .SYNC_STAGES (2),
        .FILT_W      (4),
        .RST_VAL     (1'b0)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .async_in  (async_in),
        .edge_mode (edge_mode),
        .filt_thr  (filt_thr),
        .evt_clr   (evt_clr),
        .irq_en    (irq_en),
        .lvl_out   (lvl_out),
        .pulse_out (pulse_out),
        .evt_flag  (evt_flag),
        .evt_ovf   (evt_ovf),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rstn      = 1'b0;
        async_in  = 4'b0000;
        edge_mode = 8'b11_01_10_01;  // ch3 both, ch2 rise, ch1 fall, ch0 rise
        filt_thr  = 4'd0;
        evt_clr   = 4'b0000;
        irq_en    = 4'b0000;

        // Reset and quiescent idle
        tick(); tick(); tick();
        rstn = 1'b1;
        for (int c = 0; c < 20; c++) begin
            chk("idle_outputs", {lvl_out, pulse_out, evt_flag, evt_ovf, 3'b000, irq}, 32'h0);
            tick();
        end

        // Basic latency, filt_thr = 0, ch0 rise
        async_in[0] = 1'b1;
        tick();                                   // edge k
        chk("lat_k_lvl", lvl_out, 4'b0000);
        tick();                                   // k+1
        chk("lat_k1_lvl", lvl_out, 4'b0000);
        tick();                                   // k+2
        chk("lat_k2_lvl", lvl_out, 4'b0001);
        chk("lat_k2_pulse", pulse_out, 4'b0001);
        chk("lat_k2_flag", evt_flag, 4'b0000);
        tick();                                   // k+3
        chk("lat_k3_pulse", pulse_out, 4'b0000);
        chk("lat_k3_flag", evt_flag, 4'b0001);

        // Glitch filter, filt_thr = 3, ch2: 3-cycle glitch dropped
        filt_thr    = 4'd3;
        async_in[2] = 1'b1;
        tick(); tick(); tick();
        async_in[2] = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("glitch3_lvl", lvl_out, 4'b0001);
            chk("glitch3_pulse", pulse_out, 4'b0000);
        end

        // 4-cycle high is accepted at k+5
        async_in[2] = 1'b1;
        tick(); tick(); tick(); tick();           // after k+3
        async_in[2] = 1'b0;
        tick();                                   // k+4
        chk("filt4_k4_lvl", lvl_out, 4'b0001);
        chk("filt4_k4_pulse", pulse_out, 4'b0000);
        tick();                                   // k+5
        chk("filt4_k5_lvl", lvl_out, 4'b0101);
        chk("filt4_k5_pulse", pulse_out, 4'b0100);
        tick();                                   // k+6
        chk("filt4_k6_flag", evt_flag, 4'b0101);
        tick(); tick();                           // k+8
        chk("filt4_fall_hold", lvl_out, 4'b0101);
        tick();                                   // k+9: fall accepted, mode rise only
        chk("filt4_fall_lvl", lvl_out, 4'b0001);
        chk("filt4_fall_pulse", pulse_out, 4'b0000);

        // Edge modes on ch1, filt_thr = 0
        filt_thr    = 4'd0;
        tick();
        async_in[1] = 1'b1;
        tick(); tick(); tick();
        chk("m10_rise_lvl", lvl_out, 4'b0011);
        chk("m10_rise_pulse", pulse_out, 4'b0000);
        tick();
        chk("m10_rise_flag", evt_flag, 4'b0101);
        async_in[1] = 1'b0;
        tick(); tick(); tick();
        chk("m10_fall_lvl", lvl_out, 4'b0001);
        chk("m10_fall_pulse", pulse_out, 4'b0010);
        tick();
        chk("m10_fall_pulse_end", pulse_out, 4'b0000);
        chk("m10_fall_flag", evt_flag, 4'b0111);
        chk("m10_fall_ovf", evt_ovf, 4'b0000);

        // Mode 11: rise pulses and overflows the already-set flag
        edge_mode   = 8'b11_01_11_01;
        async_in[1] = 1'b1;
        tick(); tick(); tick();
        chk("m11_rise_pulse", pulse_out, 4'b0010);
        tick();
        chk("m11_rise_ovf", evt_ovf, 4'b0010);
        chk("m11_rise_flag", evt_flag, 4'b0111);
        async_in[1] = 1'b0;
        tick(); tick();
        chk("m11_ovf_hold", evt_ovf, 4'b0010);
        tick();
        chk("m11_fall_pulse", pulse_out, 4'b0010);

        // Clear together with a pulse: flag stays, overflow cleared
        evt_clr = 4'b0010;
        tick();
        evt_clr = 4'b0000;
        chk("clr_pulse_flag", evt_flag, 4'b0111);
        chk("clr_pulse_ovf", evt_ovf, 4'b0000);
        evt_clr = 4'b0001;
        tick();
        evt_clr = 4'b0000;
        chk("clr_only_flag", evt_flag, 4'b0110);

        // irq masking
        evt_clr = 4'b1111;
        tick();
        evt_clr = 4'b0000;
        chk("clr_all_flag", evt_flag, 4'b0000);
        tick();
        chk("irq_idle", {31'd0, irq}, 32'd0);
        irq_en      = 4'b0010;
        async_in[0] = 1'b0;
        tick(); tick(); tick();
        chk("ch0_fall_lvl", lvl_out, 4'b0000);
        chk("ch0_fall_pulse", pulse_out, 4'b0000);
        async_in[0] = 1'b1;
        tick(); tick(); tick();
        chk("ch0_rise_pulse", pulse_out, 4'b0001);
        tick();
        chk("ch0_rise_flag", evt_flag, 4'b0001);
        tick();
        chk("irq_masked_a", {31'd0, irq}, 32'd0);
        tick();
        chk("irq_masked_b", {31'd0, irq}, 32'd0);
        irq_en = 4'b0011;
        tick();
        chk("irq_enabled", {31'd0, irq}, 32'd1);
        irq_en = 4'b0010;
        tick();
        chk("irq_remasked", {31'd0, irq}, 32'd0);
        chk("irq_mask_keeps_flag", evt_flag, 4'b0001);

        // Reset in the middle of a filter count on ch3
        filt_thr    = 4'd3;
        async_in[3] = 1'b1;
        tick(); tick(); tick(); tick();
        chk("pre_rst_lvl", lvl_out, 4'b0001);
        rstn     = 1'b0;
        async_in = 4'b0000;
        #1;
        chk("rst_outputs", {lvl_out, pulse_out, evt_flag, evt_ovf, 3'b000, irq}, 32'h0);
        tick();
        rstn = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("post_rst_quiet", {lvl_out, pulse_out, evt_flag, evt_ovf, 3'b000, irq}, 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
